// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared player mode encodings, mode helpers and note codes
package player_pkg;

    typedef enum logic [3:0] {
        MODE_SEL1   = 4'd0,
        MODE_SEL2   = 4'd1,
        MODE_PLAY1  = 4'd2,
        MODE_PLAY2  = 4'd3,
        MODE_ENDING = 4'd4,
        MODE_P1_PS  = 4'd5,
        MODE_P1_PM  = 4'd6,
        MODE_P2_PS  = 4'd7,
        MODE_P2_PM  = 4'd8
    } mode_e;

    localparam logic [5:0] NOTE_REST = 6'd0;
    localparam logic [5:0] NOTE_C4   = 6'd1;
    localparam logic [5:0] NOTE_D4   = 6'd3;
    localparam logic [5:0] NOTE_E4   = 6'd5;
    localparam logic [5:0] NOTE_F4   = 6'd6;
    localparam logic [5:0] NOTE_G4   = 6'd8;
    localparam logic [5:0] NOTE_A4   = 6'd10;
    localparam logic [5:0] NOTE_B4   = 6'd12;
    localparam logic [5:0] NOTE_C5   = 6'd13;

    function automatic logic is_play(input logic [3:0] m);
        return (m == MODE_PLAY1) || (m == MODE_PLAY2);
    endfunction

    function automatic logic is_pause(input logic [3:0] m);
        return (m == MODE_P1_PS) || (m == MODE_P1_PM) ||
               (m == MODE_P2_PS) || (m == MODE_P2_PM);
    endfunction

    function automatic logic is_select(input logic [3:0] m);
        return (m == MODE_SEL1) || (m == MODE_SEL2);
    endfunction

    function automatic logic song_of(input logic [3:0] m);
        return (m == MODE_PLAY2) || (m == MODE_P2_PS) || (m == MODE_P2_PM);
    endfunction

endpackage

// File: rtl/song_rom.sv
// rtl/song_rom.sv - registered per-song note table; each song repeats a 16-note phrase
module song_rom
    import player_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             song,
    input  logic [IDX_W-1:0] idx,
    output logic [5:0]       code
);

    logic [5:0]  code_q;
    logic [5:0]  code_d;
    int unsigned row;

    always_comb begin
        row    = int'(idx) % 16;
        code_d = NOTE_REST;
        if (!song) begin
            case (row)
                0:  code_d = NOTE_C4;
                1:  code_d = NOTE_D4;
                2:  code_d = NOTE_E4;
                3:  code_d = NOTE_F4;
                4:  code_d = NOTE_G4;
                5:  code_d = NOTE_A4;
                6:  code_d = NOTE_B4;
                7:  code_d = NOTE_C5;
                8:  code_d = NOTE_REST;
                9:  code_d = NOTE_C5;
                10: code_d = NOTE_B4;
                11: code_d = NOTE_A4;
                12: code_d = NOTE_G4;
                13: code_d = NOTE_F4;
                14: code_d = NOTE_E4;
                15: code_d = NOTE_D4;
                default: code_d = NOTE_REST;
            endcase
        end else begin
            case (row)
                0:  code_d = NOTE_E4;
                1:  code_d = NOTE_E4;
                2:  code_d = NOTE_F4;
                3:  code_d = NOTE_G4;
                4:  code_d = NOTE_G4;
                5:  code_d = NOTE_F4;
                6:  code_d = NOTE_E4;
                7:  code_d = NOTE_D4;
                8:  code_d = NOTE_C4;
                9:  code_d = NOTE_C4;
                10: code_d = NOTE_D4;
                11: code_d = NOTE_E4;
                12: code_d = NOTE_E4;
                13: code_d = NOTE_D4;
                14: code_d = NOTE_D4;
                15: code_d = NOTE_REST;
                default: code_d = NOTE_REST;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) code_q <= NOTE_REST;
        else     code_q <= code_d;
    end

    assign code = code_q;

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - beat prescaler, note index stepping and tone staging per player mode
module song_sequencer
    import player_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BEAT_HZ   = 8,
    parameter int SONG1_LEN = 128,
    parameter int SONG2_LEN = 128,
    parameter int IDX_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       mode,
    output logic [IDX_W-1:0] note_idx,
    output logic [5:0]       tone,
    output logic             audio_en,
    output logic             ending_sign
);

    localparam int P  = CLK_HZ / BEAT_HZ;
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    logic [PW-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cur_song_q, cur_song_d;
    logic             done_q, done_d;
    logic             ending_q, ending_d;
    logic             audio_q, audio_d;
    logic             mute_q, mute_d;

    logic             play, pause, song_m, sw, eff_song, tick;
    logic [IDX_W-1:0] eff_idx, last_idx;
    logic [5:0]       rom_code;

    always_comb begin
        play     = is_play(mode);
        pause    = is_pause(mode);
        song_m   = song_of(mode);
        sw       = play && (song_m != cur_song_q);
        // A song switch reads the new song's first note right away so no stale tone leaks out.
        eff_song = sw ? song_m : cur_song_q;
        eff_idx  = sw ? '0 : idx_q;
        last_idx = eff_song ? IDX_W'(SONG2_LEN - 1) : IDX_W'(SONG1_LEN - 1);
        tick     = (presc_q == PW'(P - 1));

        presc_d    = presc_q;
        idx_d      = idx_q;
        cur_song_d = cur_song_q;
        done_d     = done_q;
        ending_d   = ending_q;
        audio_d    = 1'b0;
        mute_d     = mute_q;

        if (play) begin
            cur_song_d = song_m;
            mute_d     = 1'b0;
            if (sw) begin
                presc_d = '0;
                idx_d   = '0;
                done_d  = 1'b0;
                audio_d = 1'b1;
            end else if (!done_q) begin
                audio_d = 1'b1;
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (idx_q < last_idx) idx_d  = idx_q + IDX_W'(1);
                    else                  done_d = 1'b1;
                end
            end
            ending_d = done_d;
        end else if (!pause) begin
            presc_d = '0;
            idx_d   = '0;
            done_d  = 1'b0;
            mute_d  = 1'b1;
            if (is_select(mode)) ending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            idx_q      <= '0;
            cur_song_q <= 1'b0;
            done_q     <= 1'b0;
            ending_q   <= 1'b0;
            audio_q    <= 1'b0;
            mute_q     <= 1'b1;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            cur_song_q <= cur_song_d;
            done_q     <= done_d;
            ending_q   <= ending_d;
            audio_q    <= audio_d;
            mute_q     <= mute_d;
        end
    end

    song_rom #(.IDX_W(IDX_W)) u_rom (
        .clk  (clk),
        .rst  (rst),
        .song (eff_song),
        .idx  (eff_idx),
        .code (rom_code)
    );

    assign note_idx    = idx_q;
    assign tone        = mute_q ? NOTE_REST : rom_code;
    assign audio_en    = audio_q;
    assign ending_sign = ending_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - directed plus randomized checks of song_sequencer against a beat-level model
module tb_song_sequencer;

    localparam int P     = 4;
    localparam int L1    = 4;
    localparam int L2    = 3;
    localparam int IDX_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       mode;
    logic [IDX_W-1:0] note_idx;
    logic [5:0]       tone;
    logic             audio_en;
    logic             ending_sign;

    int errors = 0;
    int checks = 0;

    logic [5:0] rom_t [2][16] = '{
        '{6'd1, 6'd3, 6'd5, 6'd6, 6'd8, 6'd10, 6'd12, 6'd13,
          6'd0, 6'd13, 6'd12, 6'd10, 6'd8, 6'd6, 6'd5, 6'd3},
        '{6'd5, 6'd5, 6'd6, 6'd8, 6'd8, 6'd6, 6'd5, 6'd3,
          6'd1, 6'd1, 6'd3, 6'd5, 6'd5, 6'd3, 6'd3, 6'd0}
    };

    int   m_song, m_pos, m_idx;
    bit   m_done, m_end, m_aud, m_mute;
    int   m_tone;

    song_sequencer #(
        .CLK_HZ    (16),
        .BEAT_HZ   (4),
        .SONG1_LEN (L1),
        .SONG2_LEN (L2),
        .IDX_W     (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .note_idx    (note_idx),
        .tone        (tone),
        .audio_en    (audio_en),
        .ending_sign (ending_sign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_song = 0; m_pos = 0; m_idx = 0;
        m_done = 0; m_end = 0; m_aud = 0; m_mute = 1; m_tone = 0;
    endtask

    // One clock of the player: what the outputs show after the edge that closes a cycle in mode m.
    task automatic model(input logic [3:0] m);
        int s;
        int len;
        if (m == 4'd2 || m == 4'd3) begin
            s = (m == 4'd3) ? 1 : 0;
            len = s ? L2 : L1;
            m_mute = 0;
            if (s != m_song) begin
                m_song = s; m_pos = 0; m_idx = 0; m_done = 0;
                m_aud = 1; m_tone = rom_t[s][0];
            end else begin
                m_aud = !m_done;
                m_tone = rom_t[s][m_idx % 16];
                if (!m_done) begin
                    if (m_pos == P - 1) begin
                        m_pos = 0;
                        if (m_idx == len - 1) m_done = 1;
                        else m_idx++;
                    end else begin
                        m_pos++;
                    end
                end
            end
            m_end = m_done;
        end else if (m >= 4'd5 && m <= 4'd8) begin
            m_aud = 0;
            m_tone = m_mute ? 0 : rom_t[m_song][m_idx % 16];
        end else begin
            m_pos = 0; m_idx = 0; m_done = 0;
            m_aud = 0; m_mute = 1; m_tone = 0;
            if (m <= 4'd1) m_end = 0;
        end
    endtask

    task automatic step(input logic [3:0] m, input string tag);
        mode = m;
        @(posedge clk);
        model(m);
        #1;
        chk({tag, ".idx"},    32'(note_idx),    32'(m_idx));
        chk({tag, ".tone"},   32'(tone),        32'(m_tone));
        chk({tag, ".aud"},    32'(audio_en),    32'(m_aud));
        chk({tag, ".end"},    32'(ending_sign), 32'(m_end));
    endtask

    initial begin
        logic [3:0] rm;
        int run;

        rst = 1'b1;
        mode = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.idx",  32'(note_idx),    0);
        chk("rst.tone", 32'(tone),        0);
        chk("rst.aud",  32'(audio_en),    0);
        chk("rst.end",  32'(ending_sign), 0);
        rst = 1'b0;

        for (int i = 1; i <= 20; i++) begin
            step(4'd2, "play1");
            chk("play1.idx_beat", 32'(note_idx), (i / P > L1 - 1) ? L1 - 1 : i / P);
            chk("play1.end_beat", 32'(ending_sign), (i >= P * L1) ? 1 : 0);
        end
        chk("play1.aud_after_end", 32'(audio_en), 0);

        step(4'd0, "sel");
        for (int i = 0; i < 9; i++) step(4'd2, "pre_pause");
        chk("pre_pause.idx", 32'(note_idx), 2);
        for (int i = 0; i < 10; i++) begin
            step(4'd5, "pause");
            chk("pause.idx_frozen", 32'(note_idx), 2);
        end
        step(4'd2, "resume");
        step(4'd2, "resume");
        chk("resume.no_early", 32'(note_idx), 2);
        step(4'd2, "resume");
        chk("resume.next", 32'(note_idx), 3);

        for (int i = 0; i < 6; i++) step(4'd2, "to_end");
        chk("to_end.end", 32'(ending_sign), 1);
        for (int i = 0; i < 3; i++) begin
            step(4'd4, "ending");
            chk("ending.hold", 32'(ending_sign), 1);
        end
        step(4'd0, "sel_clr");
        chk("sel_clr.end", 32'(ending_sign), 0);
        chk("sel_clr.idx", 32'(note_idx), 0);

        for (int i = 0; i < 14; i++) step(4'd3, "play2");
        chk("play2.end", 32'(ending_sign), 1);
        chk("play2.idx", 32'(note_idx), L2 - 1);
        step(4'd8, "p2pm");
        step(4'd1, "sel2");
        step(4'd2, "back1");
        chk("back1.idx",  32'(note_idx), 0);
        chk("back1.tone", 32'(tone), 32'(rom_t[0][0]));
        step(4'd2, "back1");

        step(4'd0, "sel");
        for (int i = 0; i < 3; i++) step(4'd2, "pretick");
        step(4'd6, "pm_on_tick");
        chk("pm_on_tick.idx", 32'(note_idx), 0);
        step(4'd2, "after_pm");
        chk("after_pm.idx", 32'(note_idx), 1);

        step(4'd0, "sel");
        for (int i = 0; i < 9; i++) step(4'd2, "pre_rst");
        chk("pre_rst.idx", 32'(note_idx), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.idx",  32'(note_idx),    0);
        chk("midrst.tone", 32'(tone),        0);
        chk("midrst.aud",  32'(audio_en),    0);
        chk("midrst.end",  32'(ending_sign), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step(4'd2, "post_rst");
            chk("post_rst.idx", 32'(note_idx), (i == 4) ? 1 : 0);
        end

        for (int n = 0; n < 120; n++) begin
            run = $urandom_range(0, 99);
            if (run < 45)      rm = 4'(2 + $urandom_range(0, 1));
            else if (run < 65) rm = 4'(5 + $urandom_range(0, 3));
            else if (run < 85) rm = 4'($urandom_range(0, 1));
            else               rm = 4'($urandom_range(4, 15));
            run = (rm == 4'd2 || rm == 4'd3) ? $urandom_range(4, 20) : $urandom_range(1, 6);
            for (int k = 0; k < run; k++) step(rm, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
